// File: rtl/vecseq_pkg.sv
// ============================================================================
// Module      : vecseq_pkg
// Description : Shared types and helpers for the vector_sequencer block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vecseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_DEF_VEC_W = 42;
    localparam int c_DEF_OUT_W = 8;

    // Default entry layout; the top re-declares it with its own widths.
    typedef struct packed {
        logic [c_DEF_VEC_W-1:0] ctrl;
        logic [c_DEF_OUT_W-1:0] exp;
        logic [c_DEF_OUT_W-1:0] mask;
    } vec_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : vecseq_pkg

`default_nettype wire

// File: rtl/vecseq_mem.sv
// ============================================================================
// Module      : vecseq_mem
// Description : Single-write / single-read synchronous vector RAM with a
//               registered, resettable read port (read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vecseq_mem
    import vecseq_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter int  AW      = 4,
    parameter type ENTRY_T = vec_entry_t
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  ENTRY_T        i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output ENTRY_T        o_rd_data
);

    ENTRY_T r_mem [DEPTH];
    ENTRY_T r_rd_data;

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-edge write is not visible here: the read returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : vecseq_mem

`default_nettype wire

// File: rtl/vector_sequencer.sv
// ============================================================================
// Module      : vector_sequencer
// Description : Test-vector player/checker. Replays stored control vectors
//               one per SETTLE-cycle period and, when VECSEQ_CHECK_EN is
//               defined, compares a datapath output against masked expects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_sequencer
    import vecseq_pkg::*;
#(
    parameter int VEC_W       = 42,
    parameter int DEPTH       = 16,
    parameter int OUT_W       = 8,
    parameter int SETTLE      = 1,
    parameter int ERR_W       = 8,
    parameter int STOP_ON_ERR = 0,
    localparam int AW         = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [AW:0]      i_num_vec,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [VEC_W-1:0] i_wr_ctrl,
    input  logic [OUT_W-1:0] i_wr_exp,
    input  logic [OUT_W-1:0] i_wr_mask,
    input  logic [OUT_W-1:0] i_dut_out,
    output logic [VEC_W-1:0] o_ctrl,
    output logic             o_busy,
    output logic             o_done,
    output logic [AW:0]      o_vec_idx,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_err_flag,
    output logic [AW:0]      o_first_err_idx
);

    localparam int          SW             = (clog2(SETTLE) < 1) ? 1 : clog2(SETTLE);
    localparam logic [AW:0] c_DEPTH_N      = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] c_SETTLE_LD  = SW'(SETTLE - 1);

    typedef struct packed {
        logic [VEC_W-1:0] ctrl;
`ifdef VECSEQ_CHECK_EN
        logic [OUT_W-1:0] exp;
        logic [OUT_W-1:0] mask;
`endif
    } entry_t;

    state_t           r_state;
    logic [AW:0]      r_num;
    logic [AW:0]      r_vec_idx;
    logic [AW:0]      r_first_err;
    logic [SW-1:0]    r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_err_flag;
    logic [ERR_W-1:0] r_err_cnt;

    entry_t           w_wr_entry;
    entry_t           w_rd_entry;
    logic             w_idle;
    logic             w_accept;
    logic [AW:0]      w_clamped;
    logic             w_period_end;
    logic             w_last;
    logic             w_mismatch;
    logic             w_stop;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_addr;
    logic [AW-1:0]    w_next_addr;

    assign w_idle       = (r_state != ST_RUN);
    assign w_accept     = i_start && w_idle;
    assign w_clamped    = (i_num_vec > c_DEPTH_N) ? c_DEPTH_N : i_num_vec;
    assign w_period_end = (r_state == ST_RUN) && (r_settle == '0);
    assign w_last       = (r_vec_idx == (r_num - (AW+1)'(1)));
    assign w_next_addr  = r_vec_idx[AW-1:0] + AW'(1);

`ifdef VECSEQ_CHECK_EN
    localparam bit c_STOP = (STOP_ON_ERR != 0);
    assign w_mismatch = |((i_dut_out ^ w_rd_entry.exp) & w_rd_entry.mask);
`else
    localparam bit c_STOP = 1'b0;
    logic w_unused_inputs;
    assign w_unused_inputs = ^{i_wr_exp, i_wr_mask, i_dut_out};
    assign w_mismatch      = 1'b0;
`endif

    assign w_stop = w_mismatch && c_STOP;

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.ctrl = i_wr_ctrl;
`ifdef VECSEQ_CHECK_EN
        w_wr_entry.exp  = i_wr_exp;
        w_wr_entry.mask = i_wr_mask;
`endif
    end

    // The RAM read register doubles as the ctrl output register, so a read
    // is issued only when a new vector must appear on the next edge.
    assign w_rd_en   = (w_accept && (w_clamped != '0)) ||
                       (w_period_end && !w_last && !w_stop);
    assign w_rd_addr = w_accept ? '0 : w_next_addr;

    vecseq_mem #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ENTRY_T (entry_t)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_wr_en && w_idle),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_num       <= '0;
            r_vec_idx   <= '0;
            r_first_err <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_num       <= w_clamped;
                        r_vec_idx   <= '0;
                        r_first_err <= '0;
                        r_err_flag  <= 1'b0;
                        r_err_cnt   <= '0;
                        if (w_clamped == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= ST_RUN;
                            r_settle <= c_SETTLE_LD;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - SW'(1);
                    end else begin
                        if (w_mismatch) begin
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            end
                            if (!r_err_flag) begin
                                r_first_err <= r_vec_idx;
                            end
                            r_err_flag <= 1'b1;
                        end
                        if (w_last || w_stop) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_vec_idx <= r_vec_idx + (AW+1)'(1);
                            r_settle  <= c_SETTLE_LD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ctrl          = w_rd_entry.ctrl;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_vec_idx       = r_vec_idx;
    assign o_err_count     = r_err_cnt;
    assign o_err_flag      = r_err_flag;
    assign o_first_err_idx = r_first_err;

endmodule : vector_sequencer

`default_nettype wire
